// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : MIPS execute stage: operand select, ALU, data SRAM request,
//            forwarding to decode, and a 32-iteration restoring divider.
// Revision : 1.0  initial release
// ============================================================================
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [140:0] ex_to_mem_bus,
    output logic [37:0]  ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq_for_ex
);

    localparam int                 c_CNT_W   = $clog2(DIV_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [158:0] r_id_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_ex <= '0;
        end else if (stall[2] && !stall[3]) begin
            r_id_ex <= '0;
        end else if (!stall[2]) begin
            r_id_ex <= id_to_ex_bus;
        end
    end

    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel_src1;
    logic [3:0]  w_sel_src2;
    logic        w_dram_en;
    logic [3:0]  w_dram_wen;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic        w_sel_rf_res;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;

    assign w_pc         = r_id_ex[158:127];
    assign w_inst       = r_id_ex[126:95];
    assign w_alu_op     = r_id_ex[94:83];
    assign w_sel_src1   = r_id_ex[82:80];
    assign w_sel_src2   = r_id_ex[79:76];
    assign w_dram_en    = r_id_ex[75];
    assign w_dram_wen   = r_id_ex[74:71];
    assign w_rf_we      = r_id_ex[70];
    assign w_rf_waddr   = r_id_ex[69:65];
    assign w_sel_rf_res = r_id_ex[64];
    assign w_rdata1     = r_id_ex[63:32];
    assign w_rdata2     = r_id_ex[31:0];

    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [4:0]  w_shamt;
    logic [31:0] w_sra;
    logic [31:0] w_alu_result;

    assign w_src1 = ({32{w_sel_src1[0]}} & w_rdata1)
                  | ({32{w_sel_src1[1]}} & w_pc)
                  | ({32{w_sel_src1[2]}} & {27'b0, w_inst[10:6]});

    assign w_src2 = ({32{w_sel_src2[0]}} & w_rdata2)
                  | ({32{w_sel_src2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                  | ({32{w_sel_src2[2]}} & 32'd8)
                  | ({32{w_sel_src2[3]}} & {16'b0, w_inst[15:0]});

    assign w_shamt = w_src1[4:0];
    assign w_sra   = $unsigned($signed(w_src2) >>> w_shamt);

    // alu_op is one-hot, so OR-ing the gated results selects exactly one
    always_comb begin
        w_alu_result = '0;
        if (w_alu_op[11]) w_alu_result = w_alu_result | (w_src1 + w_src2);
        if (w_alu_op[10]) w_alu_result = w_alu_result | (w_src1 - w_src2);
        if (w_alu_op[9])  w_alu_result = w_alu_result | {31'b0, $signed(w_src1) < $signed(w_src2)};
        if (w_alu_op[8])  w_alu_result = w_alu_result | {31'b0, w_src1 < w_src2};
        if (w_alu_op[7])  w_alu_result = w_alu_result | (w_src1 & w_src2);
        if (w_alu_op[6])  w_alu_result = w_alu_result | ~(w_src1 | w_src2);
        if (w_alu_op[5])  w_alu_result = w_alu_result | (w_src1 | w_src2);
        if (w_alu_op[4])  w_alu_result = w_alu_result | (w_src1 ^ w_src2);
        if (w_alu_op[3])  w_alu_result = w_alu_result | (w_src2 << w_shamt);
        if (w_alu_op[2])  w_alu_result = w_alu_result | (w_src2 >> w_shamt);
        if (w_alu_op[1])  w_alu_result = w_alu_result | w_sra;
        if (w_alu_op[0])  w_alu_result = w_alu_result | {w_src2[15:0], 16'b0};
    end

    logic        w_div_enc;
    logic        w_div_signed;
    logic        w_is_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_div_enc    = (w_inst[31:26] == 6'h00) && (w_inst[15:6] == 10'h000);
    assign w_div_signed = w_div_enc && (w_inst[5:0] == 6'h1A);
    assign w_is_div     = w_div_signed || (w_div_enc && (w_inst[5:0] == 6'h1B));
    assign w_abs_a      = (w_div_signed && w_rdata1[31]) ? -w_rdata1 : w_rdata1;
    assign w_abs_b      = (w_div_signed && w_rdata2[31]) ? -w_rdata2 : w_rdata2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_quot;
    logic [31:0]        r_rem;
    logic [31:0]        r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;

    // Partial remainder shifted left with the next dividend bit; bit 32 of the
    // trial subtraction is the borrow, so the quotient bit is its inverse.
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_ge;

    assign w_shift = {r_rem, r_quot[31]};
    assign w_trial = w_shift - {1'b0, r_divisor};
    assign w_ge    = !w_trial[32];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_is_div) begin
                        r_cnt <= '0;
                        if (w_rdata2 == 32'h0) begin
                            r_quot  <= 32'hFFFF_FFFF;
                            r_rem   <= w_rdata1;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_quot    <= w_abs_a;
                            r_rem     <= '0;
                            r_divisor <= w_abs_b;
                            r_neg_q   <= w_div_signed && (w_rdata1[31] ^ w_rdata2[31]);
                            r_neg_r   <= w_div_signed && w_rdata1[31];
                            r_state   <= c_ST_BUSY;
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_quot <= {r_quot[30:0], w_ge};
                    r_rem  <= w_ge ? w_trial[31:0] : w_shift[31:0];
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_DONE: begin
                    // Leave only when the divide actually moves on out of EX
                    if (!stall[3]) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    logic        w_done;
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    assign w_done = (r_state == c_ST_DONE);
    assign w_lo   = w_done ? (r_neg_q ? -r_quot : r_quot) : 32'h0;
    assign w_hi   = w_done ? (r_neg_r ? -r_rem : r_rem) : 32'h0;

    assign stallreq_for_ex = ((r_state == c_ST_IDLE) && w_is_div) || (r_state == c_ST_BUSY);

    assign ex_to_mem_bus = {w_pc, w_dram_en, w_dram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr,
                            w_alu_result, w_done, w_hi, w_lo};
    assign ex_to_id_bus  = {w_rf_we, w_rf_waddr, w_alu_result};

    assign data_sram_en    = w_dram_en;
    assign data_sram_wen   = w_dram_wen;
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rdata2;

    logic w_unused_ok;
    assign w_unused_ok = ^{stall[5:4], stall[1:0], w_inst[25:16]};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Self-checking bench for ex_stage (ALU, SRAM, stall, divider).
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   tb_stall;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [140:0] ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq_for_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stands in for the pipeline controller: an EX stall request freezes IF..EX
    assign stall = stallreq_for_ex ? 6'b001111 : tb_stall;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        logic        den;
        logic [3:0]  dwen;
        logic        we;
        logic [4:0]  waddr;
        logic        selres;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] res;
    } alu_vec_t;

    typedef struct {
        string        name;
        logic [140:0] mem;
        logic [37:0]  id;
        logic [68:0]  sram;
    } alu_exp_t;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          cycles;
    } div_vec_t;

    typedef struct {
        string        name;
        logic [140:0] mem;
        int           cycles;
    } div_exp_t;

    alu_exp_t alu_q[$];
    div_exp_t div_q[$];

    localparam logic [31:0] c_DIV_PC = 32'hBFC0_0100;

    function automatic logic [158:0] mk_bus(logic [31:0] pc, logic [31:0] inst, logic [11:0] op,
                                            logic [2:0] s1, logic [3:0] s2, logic den,
                                            logic [3:0] dwen, logic we, logic [4:0] waddr,
                                            logic selres, logic [31:0] r1, logic [31:0] r2);
        return {pc, inst, op, s1, s2, den, dwen, we, waddr, selres, r1, r2};
    endfunction

    function automatic logic [140:0] mk_mem(logic [31:0] pc, logic den, logic [3:0] dwen,
                                            logic selres, logic we, logic [4:0] waddr,
                                            logic [31:0] res, logic hwe, logic [31:0] hi,
                                            logic [31:0] lo);
        return {pc, den, dwen, selres, we, waddr, res, hwe, hi, lo};
    endfunction

    function automatic logic [158:0] div_bus(logic sgn, logic [31:0] a, logic [31:0] b);
        logic [5:0] func;
        func = sgn ? 6'h1A : 6'h1B;
        return mk_bus(c_DIV_PC, {6'h00, 5'd4, 5'd5, 10'h000, func}, 12'h000, 3'b000, 4'b0000,
                      1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
    endfunction

    function automatic logic [140:0] div_done_mem(logic [31:0] hi, logic [31:0] lo);
        return mk_mem(c_DIV_PC, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, hi, lo);
    endfunction

    task automatic test_reset();
        rst          = 1'b1;
        tb_stall     = 6'b000000;
        id_to_ex_bus = mk_bus(32'hBFC0_0000, {6'h0D, 5'd1, 5'd5, 16'h0034}, 12'h020, 3'b001,
                              4'b1000, 1'b1, 4'hF, 1'b1, 5'd5, 1'b1, 32'h1200, 32'h55);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ex_to_mem_bus !== 141'h0 || ex_to_id_bus !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_buses: mem=%h id=%h, required all zero", ex_to_mem_bus, ex_to_id_bus);
        end
        n_checks++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_ex} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_sram: en=%b wen=%h addr=%h wdata=%h stallreq=%b, required all zero",
                     data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_ex);
        end
        @(negedge clk);
        rst          = 1'b0;
        id_to_ex_bus = '0;
    endtask

    task automatic test_alu();
        alu_vec_t v[$];
        alu_exp_t e;
        v.push_back('{"ori",   32'hBFC0_0000, {6'h0D, 5'd1, 5'd5, 16'h0034}, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'h0000_1200, 32'h0,          32'h0000_1234});
        v.push_back('{"jal",   32'hBFC0_0010, {6'h03, 26'h0},                12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0,          32'h0,          32'hBFC0_0018});
        v.push_back('{"sw",    32'hBFC0_0020, {6'h2B, 5'd2, 5'd3, 16'hFFFC}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,  1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 32'h7FFF_FFFC});
        v.push_back('{"subu",  32'hBFC0_0030, {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h23}, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE});
        v.push_back('{"slt",   32'hBFC0_0034, {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h2A}, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1});
        v.push_back('{"sltu0", 32'hBFC0_0038, {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h2B}, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0});
        v.push_back('{"sltu1", 32'hBFC0_003C, {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h2B}, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1});
        v.push_back('{"and",   32'hBFC0_0040, {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h24}, 12'h080, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
        v.push_back('{"nor",   32'hBFC0_0044, {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h27}, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F});
        v.push_back('{"xor",   32'hBFC0_0048, {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h26}, 12'h010, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F});
        v.push_back('{"sll",   32'hBFC0_004C, {6'h00, 5'd0, 5'd2, 5'd4, 5'd4, 6'h00}, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h0000_0001, 32'h0000_0010});
        v.push_back('{"srlv",  32'hBFC0_0050, {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h06}, 12'h004, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0000_003F, 32'h8000_0000, 32'h0000_0001});
        v.push_back('{"sra",   32'hBFC0_0054, {6'h00, 5'd0, 5'd2, 5'd4, 5'd4, 6'h03}, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h8000_0000, 32'hF800_0000});
        v.push_back('{"lui",   32'hBFC0_0058, {6'h0F, 5'd0, 5'd6, 16'hABCD}, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd6, 1'b0, 32'h0, 32'h0, 32'hABCD_0000});
        v.push_back('{"noop",  32'hBFC0_005C, {6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h21}, 12'h000, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd9, 1'b1, 32'd1, 32'd2, 32'd0});
        v.push_back('{"lw",    32'hBFC0_0060, {6'h23, 5'd1, 5'd7, 16'h8000}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd7, 1'b1, 32'h0001_0000, 32'h1234_5678, 32'h0000_8000});

        foreach (v[i]) begin
            alu_q.push_back('{v[i].name,
                              mk_mem(v[i].pc, v[i].den, v[i].dwen, v[i].selres, v[i].we, v[i].waddr,
                                     v[i].res, 1'b0, 32'h0, 32'h0),
                              {v[i].we, v[i].waddr, v[i].res},
                              {v[i].den, v[i].dwen, v[i].res, v[i].r2}});
            @(negedge clk);
            id_to_ex_bus = mk_bus(v[i].pc, v[i].inst, v[i].op, v[i].s1, v[i].s2, v[i].den, v[i].dwen,
                                  v[i].we, v[i].waddr, v[i].selres, v[i].r1, v[i].r2);
            @(posedge clk);
            #1;
            e = alu_q.pop_front();
            n_checks++;
            if (ex_to_mem_bus !== e.mem) begin
                n_fail++;
                $display("FAIL %s ex_to_mem_bus: got %h required %h", e.name, ex_to_mem_bus, e.mem);
            end
            n_checks++;
            if (ex_to_id_bus !== e.id) begin
                n_fail++;
                $display("FAIL %s ex_to_id_bus: got %h required %h", e.name, ex_to_id_bus, e.id);
            end
            n_checks++;
            if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== e.sram) begin
                n_fail++;
                $display("FAIL %s sram: got %h required %h", e.name,
                         {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, e.sram);
            end
            n_checks++;
            if (stallreq_for_ex !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stallreq: got %b required 0", e.name, stallreq_for_ex);
            end
        end
        @(negedge clk);
        id_to_ex_bus = '0;
    endtask

    task automatic test_hold_and_bubble();
        @(negedge clk);
        id_to_ex_bus = mk_bus(32'hBFC0_0200, {6'h0D, 5'd1, 5'd5, 16'h0034}, 12'h020, 3'b001, 4'b1000,
                              1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0000_1200, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        tb_stall     = 6'b001111;
        id_to_ex_bus = mk_bus(32'hBFC0_0204, {6'h03, 26'h0}, 12'h800, 3'b010, 4'b0100,
                              1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        n_checks++;
        if (ex_to_id_bus !== {1'b1, 5'd5, 32'h0000_1234}) begin
            n_fail++;
            $display("FAIL hold ex_to_id_bus: got %h required %h", ex_to_id_bus, {1'b1, 5'd5, 32'h0000_1234});
        end
        @(negedge clk);
        tb_stall = 6'b000111;
        @(posedge clk);
        #1;
        n_checks++;
        if (ex_to_mem_bus !== 141'h0 || ex_to_id_bus !== 38'h0 ||
            {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_ex} !== 70'h0) begin
            n_fail++;
            $display("FAIL bubble outputs: mem=%h id=%h addr=%h, required all zero",
                     ex_to_mem_bus, ex_to_id_bus, data_sram_addr);
        end
        @(negedge clk);
        tb_stall     = 6'b000000;
        id_to_ex_bus = '0;
    endtask

    task automatic test_div();
        div_vec_t v[$];
        div_exp_t e;
        int       cyc;
        v.push_back('{"div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33});
        v.push_back('{"divu_100_7",   1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         33});
        v.push_back('{"divu_5_0",     1'b0, 32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5,         1});
        v.push_back('{"div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         33});
        v.push_back('{"div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33});
        v.push_back('{"divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'h0,         33});
        v.push_back('{"div_m5_0",     1'b1, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFB, 1});

        foreach (v[i]) begin
            div_q.push_back('{v[i].name, div_done_mem(v[i].hi, v[i].lo), v[i].cycles});
            @(negedge clk);
            id_to_ex_bus = div_bus(v[i].sgn, v[i].a, v[i].b);
            @(posedge clk);
            #1;
            id_to_ex_bus = '0;
            cyc = 0;
            while (stallreq_for_ex === 1'b1 && cyc < 100) begin
                cyc++;
                @(posedge clk);
                #1;
            end
            e = div_q.pop_front();
            n_checks++;
            if (cyc !== e.cycles) begin
                n_fail++;
                $display("FAIL %s stall_cycles: got %0d required %0d", e.name, cyc, e.cycles);
            end
            n_checks++;
            if (ex_to_mem_bus !== e.mem) begin
                n_fail++;
                $display("FAIL %s done_bus: got %h required %h", e.name, ex_to_mem_bus, e.mem);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (ex_to_mem_bus[64] !== 1'b0 || stallreq_for_ex !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after_done: hilo_we=%b stallreq=%b required 0 0", e.name,
                         ex_to_mem_bus[64], stallreq_for_ex);
            end
        end
    endtask

    task automatic test_done_hold();
        div_exp_t e;
        int       cyc;
        div_q.push_back('{"div_hold", div_done_mem(32'hFFFF_FFFE, 32'hFFFF_FFF2), 33});
        @(negedge clk);
        id_to_ex_bus = div_bus(1'b1, 32'hFFFF_FF9C, 32'd7);
        @(posedge clk);
        #1;
        id_to_ex_bus = '0;
        cyc = 0;
        while (stallreq_for_ex === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        e = div_q.pop_front();
        tb_stall = 6'b001111;
        n_checks++;
        if (cyc !== e.cycles) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d required %0d", e.name, cyc, e.cycles);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ex_to_mem_bus !== e.mem || stallreq_for_ex !== 1'b0) begin
                n_fail++;
                $display("FAIL %s held_done[%0d]: bus=%h stallreq=%b required %h 0", e.name, k,
                         ex_to_mem_bus, stallreq_for_ex, e.mem);
            end
        end
        tb_stall = 6'b000000;
        @(posedge clk);
        #1;
        n_checks++;
        if (ex_to_mem_bus[64] !== 1'b0 || stallreq_for_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: hilo_we=%b stallreq=%b required 0 0", e.name,
                     ex_to_mem_bus[64], stallreq_for_ex);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        id_to_ex_bus = div_bus(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        id_to_ex_bus = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (stallreq_for_ex !== 1'b1) begin
            n_fail++;
            $display("FAIL busy10 stallreq: got %b required 1", stallreq_for_ex);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (stallreq_for_ex !== 1'b0 || ex_to_mem_bus !== 141'h0 || ex_to_id_bus !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: stallreq=%b mem=%h id=%h required all zero",
                     stallreq_for_ex, ex_to_mem_bus, ex_to_id_bus);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (stallreq_for_ex !== 1'b0 || ex_to_mem_bus[64] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: stallreq=%b hilo_we=%b required 0 0",
                     stallreq_for_ex, ex_to_mem_bus[64]);
        end
    endtask

    task automatic test_back_to_back();
        div_exp_t e;
        int       cyc;
        div_q.push_back('{"b2b_first",  div_done_mem(32'd2, 32'd14), 33});
        div_q.push_back('{"b2b_second", div_done_mem(32'hFFFF_FFFF, 32'hFFFF_FFFD), 33});
        @(negedge clk);
        id_to_ex_bus = div_bus(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        id_to_ex_bus = '0;
        for (int n = 0; n < 2; n++) begin
            cyc = 0;
            while (stallreq_for_ex === 1'b1 && cyc < 100) begin
                cyc++;
                @(posedge clk);
                #1;
            end
            e = div_q.pop_front();
            n_checks++;
            if (cyc !== e.cycles) begin
                n_fail++;
                $display("FAIL %s stall_cycles: got %0d required %0d", e.name, cyc, e.cycles);
            end
            n_checks++;
            if (ex_to_mem_bus !== e.mem) begin
                n_fail++;
                $display("FAIL %s done_bus: got %h required %h", e.name, ex_to_mem_bus, e.mem);
            end
            if (n == 0) begin
                id_to_ex_bus = div_bus(1'b1, 32'hFFFF_FFF9, 32'd2);
                @(posedge clk);
                #1;
                id_to_ex_bus = '0;
                n_checks++;
                if (ex_to_mem_bus[64] !== 1'b0 || stallreq_for_ex !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_handoff: hilo_we=%b stallreq=%b required 0 1",
                             ex_to_mem_bus[64], stallreq_for_ex);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        tb_stall     = 6'b000000;
        id_to_ex_bus = '0;
        test_reset();
        test_alu();
        test_hold_and_bubble();
        test_div();
        test_done_hold();
        test_reset_mid_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Latches the 159-bit decode-to-execute bus and selects ALU operands.
- Computes the ALU result and issues the data SRAM request for loads/stores.
- Forwards its write-back target to decode.
- Runs an iterative 32-cycle divider for div/divu, stalling the pipeline while it runs.

Parameters:
- DIV_CYCLES, 32, number of iterations of the restoring radix-2 divider (fixed at 32 for 32-bit operands).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  6  pipeline stall vector; Stop=1; [2]=ID, [3]=EX
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], dram_en[75], dram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}
- ex_to_mem_bus  out  141  {pc 32, dram_en 1, dram_wen 4, sel_rf_res 1, rf_we 1, rf_waddr 5, ex_result 32, hilo_we 1, hi 32, lo 32}
- ex_to_id_bus  out  38  {rf_we, rf_waddr, ex_result} for forwarding
- data_sram_en  out  1  data RAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data
- stallreq_for_ex  out  1  pipeline stall request while the divider is busy

Behaviour:
- Input register:
  - rst clears it to 0 (a bubble).
  - If stall[2]=Stop and stall[3]=NoStop, it loads 0 (bubble).
  - Else if stall[2]=NoStop, it loads id_to_ex_bus.
  - Else it holds.
- All outputs are combinational from the input register and divider state. After reset every output is 0.
- src1 (one-hot): [0] rdata1; [1] pc; [2] {27'b0, inst[10:6]}. None set -> 0.
- src2 (one-hot): [0] rdata2; [1] sign-extended inst[15:0]; [2] 32'd8; [3] zero-extended inst[15:0]. None set -> 0.
- alu_op bits, MSB first: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui. One-hot; all zero -> result 0.
  - add/sub: modulo 2^32, no overflow trap.
  - slt: signed compare; sltu: unsigned compare.
  - Shifts use src1[4:0] as the amount and src2 as the value.
  - lui: {src2[15:0], 16'b0}.
- Data SRAM outputs: en=dram_en, wen=dram_wen, addr=ex_result, wdata=rdata2. Outputs are driven in the same cycle the instruction sits in EX.
- ex_to_id_bus carries the same rf_we/rf_waddr/ex_result as ex_to_mem_bus, combinationally.
- Divide detection: inst[31:26]=0 and inst[15:6]=0. func 6'h1A is div (signed); func 6'h1B is divu (unsigned).
- Divider FSM states:
  - IDLE: when a divide is detected, capture operand magnitudes (abs value for div), clear the counter, go to BUSY.
    - Divisor 0: go straight to DONE with lo=32'hFFFFFFFF, hi=rdata1.
  - BUSY: one quotient bit per cycle. After DIV_CYCLES iterations go to DONE.
  - DONE: apply signs (div only): quotient negative iff operand signs differ; remainder takes the dividend's sign. Hold hi/lo. Return to IDLE on the first cycle stall[3]=NoStop.
- stallreq_for_ex:
  - 1 from the first cycle a divide is in EX through all BUSY cycles.
  - 0 in DONE.
  - Total stall is 33 cycles for a nonzero divisor and 1 cycle for divide-by-zero.
- hilo_we=1 only in DONE, with hi=remainder and lo=quotient. Otherwise hilo_we=0 and hi/lo=0. rf_we is passed through unchanged (decode sets 0 for div).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- If EX is held by a downstream stall (stall[3]=Stop) while in DONE, the FSM stays in DONE. It must not restart on the same instruction.
- Reset at any point, including mid-BUSY: FSM to IDLE, counter 0, stallreq 0, input register cleared.

Test Plan:
- ori: alu_op or, src1[0], src2[3], rdata1=32'h0000_1200, inst[15:0]=16'h0034 -> ex_result=32'h0000_1234, ex_to_id_bus={1,rt,32'h1234}, stallreq=0.
- jal: src1[1], src2[2], pc=32'hBFC0_0010, op add -> ex_result=32'hBFC0_0018, rf_waddr=31.
- sw: dram_en=1, wen=4'hF, rdata1=32'h8000_0000, imm=16'hFFFC, add -> data_sram_addr=32'h7FFF_FFFC, wdata=rdata2.
- div: rdata1=-7 (32'hFFFF_FFF9), rdata2=2 -> stallreq high 33 cycles; then lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF, hilo_we=1 for one cycle; repeat with divu 100/7 -> lo=14, hi=2.
- divide-by-zero: divu rdata1=5, rdata2=0 -> 1 stall cycle, then lo=32'hFFFF_FFFF, hi=5.
- bubble/reset: stall=6'b000111 loads 0 into the input register (all outputs 0); assert rst in the 10th BUSY cycle -> next cycle stallreq=0, FSM IDLE, outputs 0.
